// File: rtl/detector_alarma.sv
// Alarm-tone checker: synchronizes the buzzer tone, measures every half-period
// and reports lock, measured period and tone faults.
module detector_alarma #(
    parameter int unsigned HALF_PERIOD = 249,
    parameter int unsigned TOL         = 4,
    parameter int unsigned LOCK_COUNT  = 8,
    parameter int unsigned CNT_W       = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             habilita,
    input  logic             tono_in,
    output logic             tono_ok,
    output logic [CNT_W-1:0] periodo,
    output logic             periodo_valido,
    output logic             error_tono
);

    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SEEK    = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;
    localparam logic [1:0] S_LOCKED  = 2'd3;

    // One extra bit so cnt+1 never wraps during comparison.
    localparam logic [CNT_W:0] MEAS_MIN  = (CNT_W + 1)'(HALF_PERIOD - TOL);
    localparam logic [CNT_W:0] MEAS_MAX  = (CNT_W + 1)'(HALF_PERIOD + TOL);
    localparam logic [MW-1:0]  LOCK_MAX  = MW'(LOCK_COUNT);

    logic             s1_q, s2_q, s3_q;
    logic             flanco;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MW-1:0]    match_q, match_d;
    logic [MW-1:0]    match_inc;
    logic [CNT_W:0]   meas;
    logic             in_range;
    logic             timeout;
    logic             ok_q, ok_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    assign flanco    = s2_q ^ s3_q;
    assign meas      = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    assign in_range  = (meas >= MEAS_MIN) && (meas <= MEAS_MAX);
    assign timeout   = (meas == MEAS_MAX + (CNT_W + 1)'(1));
    assign match_inc = match_q + MW'(1);

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        ok_d    = ok_q;
        per_d   = per_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (flanco) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (!habilita) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            match_d = '0;
            ok_d    = 1'b0;
            per_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_SEEK;
                    cnt_d   = '0;
                end
                S_SEEK: begin
                    if (flanco) begin
                        state_d = S_MEASURE;
                    end
                end
                S_MEASURE, S_LOCKED: begin
                    // An edge on the timeout cycle is measured, not timed out.
                    if (flanco) begin
                        valid_d = 1'b1;
                        per_d   = meas[CNT_W-1:0];
                        if (in_range) begin
                            if (state_q == S_MEASURE) begin
                                if (match_inc == LOCK_MAX) begin
                                    state_d = S_LOCKED;
                                    ok_d    = 1'b1;
                                end
                                match_d = match_inc;
                            end
                        end else begin
                            err_d   = 1'b1;
                            match_d = '0;
                            ok_d    = 1'b0;
                            state_d = S_MEASURE;
                        end
                    end else if (timeout) begin
                        err_d   = 1'b1;
                        match_d = '0;
                        ok_d    = 1'b0;
                        state_d = S_SEEK;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            match_q <= '0;
            ok_q    <= 1'b0;
            per_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            s1_q    <= tono_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            ok_q    <= ok_d;
            per_q   <= per_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign tono_ok        = ok_q;
    assign periodo        = per_q;
    assign periodo_valido = valid_q;
    assign error_tono     = err_q;

endmodule
